// File: rtl/e_mdu_ctrl_pkg.sv
// Shared encodings and types for the E-stage multiply/divide controller.
package e_mdu_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  // MDOp codes carried from the CU into the E stage
  localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd8;

  // Controller state codes
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  // HI/LO result pair produced by the arithmetic unit
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_res_t;

  // True for the ops that occupy the unit for multiple cycles
  function automatic logic is_mul_div(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage <-> MD controller signal bundle.
interface e_mdu_ctrl_if;
  import e_mdu_ctrl_pkg::*;

  logic              start;
  logic [OP_W-1:0]   md_op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              d_is_md;
  logic              busy;
  logic              stall_md;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] md_rd;

  modport master (
    output start, md_op, A, B, d_is_md,
    input  busy, stall_md, hi, lo, md_rd
  );

  modport slave (
    input  start, md_op, A, B, d_is_md,
    output busy, stall_md, hi, lo, md_rd
  );

endinterface

// File: rtl/e_mdu_ctrl_md_arith.sv
// Combinational 64-bit multiply / 32-bit divide on the latched operands.
module e_mdu_ctrl_md_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_res_t           res,
  output logic              wr_c
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic        [DATA_W-1:0]   divisor;
  logic signed [DATA_W-1:0]   quot_s;
  logic signed [DATA_W-1:0]   rem_s;
  logic        [DATA_W-1:0]   quot_u;
  logic        [DATA_W-1:0]   rem_u;

  // Products: sign- or zero-extend to full width before multiplying
  assign prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Divide by a safe stand-in when b==0; that result is never written back
  assign divisor = (b == '0) ? DATA_W'(1) : b;
  assign quot_s  = $signed(a) / $signed(divisor);
  assign rem_s   = $signed(a) % $signed(divisor);
  assign quot_u  = a / divisor;
  assign rem_u   = a % divisor;

  // Select result by op; divide-by-zero suppresses the HI/LO write
  always_comb begin
    res  = '0;
    wr_c = 1'b0;
    case (op)
      MD_MULT: begin
        res  = md_res_t'(prod_s);
        wr_c = 1'b1;
      end
      MD_MULTU: begin
        res  = md_res_t'(prod_u);
        wr_c = 1'b1;
      end
      MD_DIV: begin
        res.hi = DATA_W'(rem_s);
        res.lo = DATA_W'(quot_s);
        wr_c   = (b != '0);
      end
      MD_DIVU: begin
        res.hi = rem_u;
        res.lo = quot_u;
        wr_c   = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency sequencing, HI/LO ownership, MD stall.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
)(
  input logic        clk,
  input logic        reset,
  e_mdu_ctrl_if.slave md
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              ld_ops;
  logic              wr_res;
  logic              wr_hi;
  logic              wr_lo;
  md_res_t           arith_res;
  logic              arith_wr;

  e_mdu_ctrl_md_arith u_md_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .res  (arith_res),
    .wr_c (arith_wr)
  );

  // State register; busy tracks the next state so it is a clean flop output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE);
    end
  end

  // Next-state, counter and datapath strobes; start is ignored while busy
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_ops    = 1'b0;
    wr_res    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      S_IDLE: begin
        if (md.start) begin
          case (md.md_op)
            MD_MULT, MD_MULTU: begin
              ld_ops    = 1'b1;
              cnt_nxt   = CNT_W'(MUL_LAT - 1);
              state_nxt = S_MUL;
            end
            MD_DIV, MD_DIVU: begin
              ld_ops    = 1'b1;
              cnt_nxt   = CNT_W'(DIV_LAT - 1);
              state_nxt = S_DIV;
            end
            MD_MTHI: wr_hi = 1'b1;
            MD_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == '0) begin
          wr_res    = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter, operand latches and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (ld_ops) begin
        op_q <= md.md_op;
        a_q  <= md.A;
        b_q  <= md.B;
      end
      if (wr_res && arith_wr) begin
        hi_q <= arith_res.hi;
        lo_q <= arith_res.lo;
      end
      if (wr_hi) hi_q <= md.A;
      if (wr_lo) lo_q <= md.A;
    end
  end

  assign md.busy     = busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_rd    = (md.md_op == MD_MFHI) ? hi_q :
                       (md.md_op == MD_MFLO) ? lo_q : '0;
  assign md.stall_md = md.d_is_md & (busy_q | (md.start & is_mul_div(md.md_op)));

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for the E-stage MD controller (MUL_LAT=5, DIV_LAT=10).
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d;
    logic        exp_stall;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NVEC = 17;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  vec_t vecs [NVEC];

  e_mdu_ctrl_if mif ();

  e_mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline never presents a new MD op while the unit is busy
  always @(posedge clk) begin
    if (reset && mif.busy && mif.start) begin
      fails++;
      $display("FAIL start_while_busy act=1 exp=0 t=%0t", $time);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Issue one op in a single cycle, then count busy cycles while scrambling A/B
  task automatic apply(input vec_t v, input string nm);
    int   lat;
    logic stall_bad;
    @(negedge clk);
    mif.start   = 1'b1;
    mif.md_op   = v.op;
    mif.A       = v.a;
    mif.B       = v.b;
    mif.d_is_md = v.d;
    #1;
    chk({nm, "_stall_issue"}, 32'(mif.stall_md), 32'(v.exp_stall));
    chk({nm, "_busy_issue"}, 32'(mif.busy), 32'(0));
    chk({nm, "_md_rd"}, mif.md_rd, v.exp_rd);
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    lat       = 0;
    stall_bad = 1'b0;
    #1;
    while (mif.busy === 1'b1 && lat < 40) begin
      if (mif.stall_md !== v.d) stall_bad = 1'b1;
      lat++;
      @(negedge clk);
      mif.A = $urandom;
      mif.B = $urandom;
      #1;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_stall_busy"}, 32'(stall_bad), 32'(0));
    chk({nm, "_stall_after"}, 32'(mif.stall_md), 32'(0));
    chk({nm, "_hi"}, mif.hi, v.exp_hi);
    chk({nm, "_lo"}, mif.lo, v.exp_lo);
  endtask

  initial begin
    vec_t rv;
    checks = 0;
    fails  = 0;

    //          op        a             b             d     st    rd            lat hi            lo
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        1'b1, 1'b1, 32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MD_DIVU,  32'd100,      32'd7,        1'b1, 1'b1, 32'h0,        10, 32'h2,        32'hE};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_MTHI,  32'd5,        32'd0,        1'b1, 1'b0, 32'h0,        0,  32'h5,        32'hFFFFFFFD};
    vecs[4]  = '{MD_MTLO,  32'd9,        32'd0,        1'b1, 1'b0, 32'h0,        0,  32'h5,        32'h9};
    vecs[5]  = '{MD_MFHI,  32'd0,        32'd0,        1'b1, 1'b0, 32'h5,        0,  32'h5,        32'h9};
    vecs[6]  = '{MD_DIV,   32'd123,      32'd0,        1'b1, 1'b1, 32'h0,        10, 32'h5,        32'h9};
    vecs[7]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd0,        1'b1, 1'b1, 32'h0,        10, 32'h5,        32'h9};
    vecs[8]  = '{MD_MFLO,  32'd0,        32'd0,        1'b1, 1'b0, 32'h9,        0,  32'h5,        32'h9};
    vecs[9]  = '{MD_MULTU, 32'h00010000, 32'h00010000, 1'b1, 1'b1, 32'h0,        5,  32'h1,        32'h0};
    vecs[10] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, 32'h0,        10, 32'h1,        32'hFFFFFFFD};
    vecs[11] = '{MD_MULT,  32'h80000000, 32'd2,        1'b0, 1'b0, 32'h0,        5,  32'hFFFFFFFF, 32'h0};
    vecs[12] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       1'b0, 1'b0, 32'h0,        10, 32'hF,        32'h0FFFFFFF};
    vecs[13] = '{MD_MFHI,  32'd0,        32'd0,        1'b1, 1'b0, 32'hF,        0,  32'hF,        32'h0FFFFFFF};
    vecs[14] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        5,  32'hFFFFFFFE, 32'h1};
    vecs[15] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        5,  32'h0,        32'h1};
    vecs[16] = '{MD_MFLO,  32'd0,        32'd0,        1'b1, 1'b0, 32'h1,        0,  32'h0,        32'h1};

    // Reset state with a D-stage MD op waiting and nothing in E
    reset       = 1'b0;
    mif.start   = 1'b0;
    mif.md_op   = MD_NONE;
    mif.A       = '0;
    mif.B       = '0;
    mif.d_is_md = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(mif.busy), 32'(0));
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    chk("rst_stall", 32'(mif.stall_md), 32'(0));
    chk("rst_md_rd", mif.md_rd, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // MTHI followed directly by MFHI: no busy, no stall, value forwarded
    @(negedge clk);
    mif.start   = 1'b1;
    mif.md_op   = MD_MTHI;
    mif.A       = 32'h1234;
    mif.d_is_md = 1'b1;
    #1;
    chk("mthi_stall", 32'(mif.stall_md), 32'(0));
    chk("mthi_busy", 32'(mif.busy), 32'(0));
    @(negedge clk);
    mif.md_op = MD_MFHI;
    mif.A     = 32'h0;
    #1;
    chk("mfhi_busy", 32'(mif.busy), 32'(0));
    chk("mfhi_stall", 32'(mif.stall_md), 32'(0));
    chk("mfhi_md_rd", mif.md_rd, 32'h1234);
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    #1;
    chk("mfhi_after_busy", 32'(mif.busy), 32'(0));

    // Reset asserted in the third busy cycle of a DIV aborts it immediately
    @(negedge clk);
    mif.start   = 1'b1;
    mif.md_op   = MD_DIV;
    mif.A       = 32'd50;
    mif.B       = 32'd3;
    mif.d_is_md = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    #1;
    chk("abort_busy1", 32'(mif.busy), 32'(1));
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_busy3", 32'(mif.busy), 32'(1));
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(mif.busy), 32'(0));
    chk("abort_hi", mif.hi, 32'h0);
    chk("abort_lo", mif.lo, 32'h0);
    chk("abort_stall_idle", 32'(mif.stall_md), 32'(0));
    mif.start = 1'b1;
    mif.md_op = MD_MULT;
    #1;
    chk("abort_stall_inputs", 32'(mif.stall_md), 32'(1));
    mif.start = 1'b0;
    mif.md_op = MD_NONE;
    @(negedge clk);
    reset = 1'b1;

    rv = '{MD_MULT, 32'd3, 32'd4, 1'b1, 1'b1, 32'h0, 5, 32'h0, 32'hC};
    apply(rv, "post_rst_mult");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
